// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl -- bit-serial adder controller.
//
// One 1-bit full-adder cell (full_adder_implicit) is stepped over WIDTH
// clock cycles. Each step adds one operand bit pair, LSB first, and a
// carry flip-flop carries the result into the next bit. This saves adder
// area at the cost of latency. A start/done handshake faces upstream
// logic. The result stays in sum/co until the next accepted start.
//
// Optional feature: define SERIAL_ADDER_OVF_EN to add the ovf output. It
// reports signed two's-complement overflow, captured together with co.
//
// Parameters
//   WIDTH   operand/result width in bits (>= 2)
//
// Ports
//   clk     rising-edge clock
//   rst_n   synchronous reset, active-low (aborts any operation)
//   start   request, sampled only while idle
//   a_in    operand A, captured on the accepting edge
//   b_in    operand B, captured on the accepting edge
//   ci_in   carry-in, captured on the accepting edge
//   busy    high while an operation is in progress (RUN or DONE)
//   done    one-cycle pulse; sum/co are valid from this cycle
//   sum     result register
//   co      final carry-out register
//   ovf     signed overflow (only with SERIAL_ADDER_OVF_EN)

module full_adder_implicit (
   input  logic ci,
   input  logic a,
   input  logic b,
   output logic co,
   output logic s
);

   assign {co, s} = {1'b0, a} + {1'b0, b} + {1'b0, ci};

endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             ci_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             co
`ifdef SERIAL_ADDER_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int CNT_W = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             load;
   logic             step;
   logic             last;

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic             cy;
   logic [CNT_W-1:0] cnt;

   logic             cell_co;
   logic             cell_s;

   full_adder_implicit u_cell (
      .ci (cy),
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .co (cell_co),
      .s  (cell_s)
   );

   // Next-state and datapath strobes
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            step = 1'b1;
            if (cnt == CNT_LAST) begin
               last      = 1'b1;
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State register; busy/done are decoded from the next state so they
   // come straight out of flops with no path from start.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         busy  <= (state_nxt != IDLE);
         done  <= (state_nxt == DONE);
      end
   end

   // Serial datapath: operands shift out LSB first, sum fills from the MSB
   // end so that after WIDTH steps bit 0 of the result sits in sum[0].
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         a_sh <= '0;
         b_sh <= '0;
         cy   <= 1'b0;
         cnt  <= '0;
         sum  <= '0;
         co   <= 1'b0;
      end else if (load) begin
         a_sh <= a_in;
         b_sh <= b_in;
         cy   <= ci_in;
         cnt  <= '0;
         sum  <= '0;
         co   <= 1'b0;
      end else if (step) begin
         a_sh <= a_sh >> 1;
         b_sh <= b_sh >> 1;
         cy   <= cell_co;
         sum  <= {cell_s, sum[WIDTH-1:1]};
         // Park the counter at zero on the last bit so it never exceeds
         // WIDTH-1 when WIDTH is not a power of two.
         cnt  <= last ? '0 : cnt + 1'b1;
         if (last) begin
            co <= cell_co;
         end
      end
   end

`ifdef SERIAL_ADDER_OVF_EN
   // On the last step cy holds the carry into the MSB, and cell_co holds
   // the carry out of it.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else if (load) begin
         ovf <= 1'b0;
      end else if (step && last) begin
         ovf <= cy ^ cell_co;
      end
   end
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Testbench for serial_adder_ctrl: directed vector table, hand-written
// multi-cycle sequences, and a random sweep on WIDTH=8 and WIDTH=3 instances
// checked against plain-arithmetic expectations.
module tb_serial_adder_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;

   logic       start8 = 1'b0;
   logic [7:0] a8 = '0;
   logic [7:0] b8 = '0;
   logic       ci8 = 1'b0;
   logic       busy8, done8, co8, ovf8;
   logic [7:0] sum8;

   logic       start3 = 1'b0;
   logic [2:0] a3 = '0;
   logic [2:0] b3 = '0;
   logic       ci3 = 1'b0;
   logic       busy3, done3, co3, ovf3;
   logic [2:0] sum3;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(8)) dut8 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start8),
      .a_in  (a8),
      .b_in  (b8),
      .ci_in (ci8),
      .busy  (busy8),
      .done  (done8),
      .sum   (sum8),
      .co    (co8)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf8)
`endif
   );

   serial_adder_ctrl #(.WIDTH(3)) dut3 (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start3),
      .a_in  (a3),
      .b_in  (b3),
      .ci_in (ci3),
      .busy  (busy3),
      .done  (done3),
      .sum   (sum3),
      .co    (co3)
`ifdef SERIAL_ADDER_OVF_EN
      ,
      .ovf   (ovf3)
`endif
   );

`ifndef SERIAL_ADDER_OVF_EN
   assign ovf8 = 1'b0;
   assign ovf3 = 1'b0;
`endif

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       ci;
      logic [7:0] s;
      logic       c;
      logic       o;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Launch one operation from a falling edge while idle and wait (bounded)
   // for done. lat counts falling edges from launch to done (-1 on timeout).
   task automatic do_op(input int w, input logic [7:0] a, input logic [7:0] b, input logic ci,
                        output logic [7:0] s, output logic c, output logic o,
                        output int lat, output bit busy_ok, output bit pulse_ok);
      logic d;
      logic bz;
      busy_ok = 1'b1;
      lat     = -1;
      if (w == 8) begin
         a8 = a; b8 = b; ci8 = ci; start8 = 1'b1;
      end else begin
         a3 = a[2:0]; b3 = b[2:0]; ci3 = ci; start3 = 1'b1;
      end
      for (int i = 1; i <= w + 6; i++) begin
         @(negedge clk);
         start8 = 1'b0;
         start3 = 1'b0;
         d  = (w == 8) ? done8 : done3;
         bz = (w == 8) ? busy8 : busy3;
         if (bz !== 1'b1) busy_ok = 1'b0;
         if (d === 1'b1) begin
            lat = i;
            break;
         end
      end
      s = (w == 8) ? sum8 : {5'b0, sum3};
      c = (w == 8) ? co8 : co3;
      o = (w == 8) ? ovf8 : ovf3;
      @(negedge clk);
      if (w == 8) pulse_ok = (done8 === 1'b0) && (busy8 === 1'b0);
      else        pulse_ok = (done3 === 1'b0) && (busy3 === 1'b0);
   endtask

   vec_t        tbl[8];
   logic [7:0]  s;
   logic        c;
   logic        o;
   int          lat;
   bit          busy_ok;
   bit          pulse_ok;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tbl[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0};
      tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[2] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0};
      tbl[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
      tbl[4] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      tbl[5] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
      tbl[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      tbl[7] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_busy", {31'b0, busy8}, 0);
      check("rst_done", {31'b0, done8}, 0);
      check("rst_sum",  {24'b0, sum8}, 0);
      check("rst_co",   {31'b0, co8}, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed table
      foreach (tbl[i]) begin
         do_op(8, tbl[i].a, tbl[i].b, tbl[i].ci, s, c, o, lat, busy_ok, pulse_ok);
         check($sformatf("tbl%0d_sum", i), {24'b0, s}, {24'b0, tbl[i].s});
         check($sformatf("tbl%0d_co", i), {31'b0, c}, {31'b0, tbl[i].c});
         check($sformatf("tbl%0d_lat", i), lat, 9);
         check($sformatf("tbl%0d_busy", i), {31'b0, busy_ok}, 1);
         check($sformatf("tbl%0d_pulse", i), {31'b0, pulse_ok}, 1);
`ifdef SERIAL_ADDER_OVF_EN
         check($sformatf("tbl%0d_ovf", i), {31'b0, o}, {31'b0, tbl[i].o});
`endif
      end

      // Result holds while idle even as the operand inputs move
      do_op(8, 8'h21, 8'h43, 1'b1, s, c, o, lat, busy_ok, pulse_ok);
      for (int i = 0; i < 5; i++) begin
         a8 = 8'($urandom); b8 = 8'($urandom);
         @(negedge clk);
      end
      check("hold_sum", {24'b0, sum8}, 32'h65);
      check("hold_co",  {31'b0, co8}, 0);

      // start held high: one result every 10 cycles, operands scrambled mid-run
      begin
         int ndone = 0;
         int last_i = -1;
         bit sp_ok = 1'b1;
         bit res_ok = 1'b1;
         start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0;
         for (int i = 1; i <= 50; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) begin
               if (last_i >= 0 && (i - last_i) != 10) sp_ok = 1'b0;
               if (sum8 !== 8'h46 || co8 !== 1'b0) res_ok = 1'b0;
               last_i = i;
               ndone++;
            end
            if (busy8 === 1'b1) begin
               a8 = 8'($urandom); b8 = 8'($urandom); ci8 = 1'($urandom);
            end else begin
               a8 = 8'h12; b8 = 8'h34; ci8 = 1'b0;
            end
         end
         start8 = 1'b0;
         check("b2b_count", ndone, 5);
         check("b2b_spacing", {31'b0, sp_ok}, 1);
         check("b2b_result", {31'b0, res_ok}, 1);
         @(negedge clk);
      end

      // Reset in the middle of RUN aborts without a done pulse
      begin
         int ndone = 0;
         a8 = 8'hFF; b8 = 8'hFF; ci8 = 1'b1; start8 = 1'b1;
         @(negedge clk);
         start8 = 1'b0;
         repeat (3) @(negedge clk);
         rst_n = 1'b0;
         @(negedge clk);
         rst_n = 1'b1;
         check("abort_busy", {31'b0, busy8}, 0);
         check("abort_done", {31'b0, done8}, 0);
         check("abort_sum",  {24'b0, sum8}, 0);
         check("abort_co",   {31'b0, co8}, 0);
         for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done8 === 1'b1) ndone++;
         end
         check("abort_no_done", ndone, 0);
         do_op(8, 8'h0F, 8'h01, 1'b0, s, c, o, lat, busy_ok, pulse_ok);
         check("after_abort", {23'b0, c, s}, 32'h010);
         check("after_abort_lat", lat, 9);
      end

      // Random sweep against plain arithmetic
      for (int w = 3; w <= 8; w += 5) begin
         int nbad = 0;
         int lbad = 0;
         int obad = 0;
         for (int n = 0; n < 1000; n++) begin
            int ai, bi, ci_i, exp, act, sa, sb, ss;
            bit exp_o;
            ai   = int'($urandom_range(0, (1 << w) - 1));
            bi   = int'($urandom_range(0, (1 << w) - 1));
            ci_i = int'($urandom_range(0, 1));
            exp  = ai + bi + ci_i;
            sa   = (ai >= (1 << (w - 1))) ? ai - (1 << w) : ai;
            sb   = (bi >= (1 << (w - 1))) ? bi - (1 << w) : bi;
            ss   = sa + sb + ci_i;
            exp_o = (ss > (1 << (w - 1)) - 1) || (ss < -(1 << (w - 1)));
            do_op(w, 8'(ai), 8'(bi), 1'(ci_i), s, c, o, lat, busy_ok, pulse_ok);
            act = int'(s) + (int'(c) << w);
            n_tests++;
            if (act != exp) begin
               n_fail++;
               nbad++;
               if (nbad <= 5)
                  $display("FAIL rnd%0d_res: %0d+%0d+%0d got %0h, expected %0h", w, ai, bi, ci_i, act, exp);
            end
            if (lat != w + 1 || !busy_ok || !pulse_ok) lbad++;
`ifdef SERIAL_ADDER_OVF_EN
            if (o !== exp_o) obad++;
`endif
         end
         check($sformatf("rnd%0d_timing", w), lbad, 0);
`ifdef SERIAL_ADDER_OVF_EN
         check($sformatf("rnd%0d_ovf", w), obad, 0);
`endif
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
